// File: rtl/aq_vpu_vfmau_wb_collect.sv
// Collects vfmau results at their real completion stage (ex3/ex4/ex5) and
// queues them in age order for a valid/ready FPR writeback port.
module aq_vpu_vfmau_wb_collect #(
  parameter int FMAU_SEL_BIT = 2,
  parameter int DEPTH        = 4,
  parameter int PREG_W       = 6,
  parameter int DATA_W       = 64
) (
  input  logic                     forever_cpuclk,
  input  logic                     cpurst,
  input  logic                     vpu_group_0_xx_ex1_sel,
  input  logic [9:0]               vpu_group_0_xx_ex1_eu_sel,
  input  logic [PREG_W-1:0]        vpu_group_0_xx_ex1_dst_preg,
  input  logic                     vpu_group_0_xx_ex1_stall,
  input  logic                     vpu_group_0_xx_ex2_stall,
  input  logic                     vpu_group_0_xx_ex3_stall,
  input  logic                     vpu_group_0_xx_ex4_stall,
  input  logic                     vpu_group_0_xx_ex5_stall,
  input  logic                     vpu_group_0_xx_flush,
  input  logic                     vfmau_vpu_ex2_result_ready_in_ex3,
  input  logic                     vfmau_vpu_ex3_result_ready_in_ex4,
  input  logic [DATA_W-1:0]        vfmau_vpu_ex3_fpr_result,
  input  logic [DATA_W-1:0]        vfmau_vpu_ex4_fpr_result,
  input  logic [DATA_W-1:0]        vfmau_vpu_ex5_fpr_result,
  input  logic [4:0]               vfmau_vpu_ex3_fflags,
  input  logic [4:0]               vfmau_vpu_ex4_fflags,
  input  logic [4:0]               vfmau_vpu_ex5_fflags,
  input  logic                     wb_ready,
  input  logic                     fflags_clr,
  output logic                     wb_vld,
  output logic [PREG_W-1:0]        wb_preg,
  output logic [DATA_W-1:0]        wb_data,
  output logic [4:0]               wb_fflags,
  output logic [4:0]               fflags_acc,
  output logic                     vfmau_stall_req,
  output logic [$clog2(DEPTH):0]   wb_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [5:1]        stall;
  logic              issue;
  logic [5:2]        vld_reg;
  logic [5:2]        done_reg;
  logic [PREG_W-1:0] preg_reg  [2:5];
  logic              prev_vld  [2:5];
  logic              prev_done [2:5];
  logic [PREG_W-1:0] prev_preg [2:5];
  logic              comp      [2:5];
  logic [DATA_W-1:0] res       [3:5];
  logic [4:0]        flg       [3:5];

  assign stall = {vpu_group_0_xx_ex5_stall, vpu_group_0_xx_ex4_stall, vpu_group_0_xx_ex3_stall,
                  vpu_group_0_xx_ex2_stall, vpu_group_0_xx_ex1_stall};
  assign issue = vpu_group_0_xx_ex1_sel & vpu_group_0_xx_ex1_eu_sel[FMAU_SEL_BIT];

  assign res[3] = vfmau_vpu_ex3_fpr_result;
  assign res[4] = vfmau_vpu_ex4_fpr_result;
  assign res[5] = vfmau_vpu_ex5_fpr_result;
  assign flg[3] = vfmau_vpu_ex3_fflags;
  assign flg[4] = vfmau_vpu_ex4_fflags;
  assign flg[5] = vfmau_vpu_ex5_fflags;

  assign prev_vld[2]  = issue;
  assign prev_preg[2] = vpu_group_0_xx_ex1_dst_preg;
  assign prev_done[2] = 1'b0;
  assign prev_done[3] = vfmau_vpu_ex2_result_ready_in_ex3;
  assign prev_done[4] = vfmau_vpu_ex3_result_ready_in_ex4;
  assign prev_done[5] = 1'b1;
  assign comp[2]      = 1'b0;

  // A completing op leaves a bubble behind it rather than moving on.
  for (genvar gi = 3; gi <= 5; gi++) begin : g_stage
    assign comp[gi]      = vld_reg[gi] & done_reg[gi] & ~stall[gi];
    assign prev_vld[gi]  = vld_reg[gi-1] & ~comp[gi-1];
    assign prev_preg[gi] = preg_reg[gi-1];
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      vld_reg  <= '0;
      done_reg <= '0;
      for (int k = 2; k <= 5; k++) preg_reg[k] <= '0;
    end else begin
      for (int k = 2; k <= 5; k++) begin
        if (vpu_group_0_xx_flush) begin
          vld_reg[k] <= 1'b0;
        end else if (!stall[k]) begin
          if (stall[k-1]) begin
            vld_reg[k] <= 1'b0;
          end else begin
            vld_reg[k]  <= prev_vld[k];
            preg_reg[k] <= prev_preg[k];
            done_reg[k] <= prev_done[k];
          end
        end
      end
    end
  end

  // Completions in age order: slot 0 = ex5 (oldest), slot 2 = ex3.
  logic              cv   [0:2];
  logic [PREG_W-1:0] cp   [0:2];
  logic [DATA_W-1:0] cd   [0:2];
  logic [4:0]        cf   [0:2];
  logic [PTR_W-1:0]  slot [0:2];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  enq;
  logic              pop;
  logic [4:0]        acc_reg;

  for (genvar gi = 0; gi < 3; gi++) begin : g_comp
    assign cv[gi] = comp[5-gi];
    assign cp[gi] = preg_reg[5-gi];
    assign cd[gi] = res[5-gi];
    assign cf[gi] = flg[5-gi];
  end

  assign slot[0] = wr_ptr_reg;
  assign slot[1] = wr_ptr_reg + PTR_W'(cv[0]);
  assign slot[2] = wr_ptr_reg + PTR_W'(cv[0]) + PTR_W'(cv[1]);
  assign enq     = CNT_W'(cv[0]) + CNT_W'(cv[1]) + CNT_W'(cv[2]);

  logic [PREG_W-1:0] mem_preg  [0:DEPTH-1];
  logic [DATA_W-1:0] mem_data  [0:DEPTH-1];
  logic [4:0]        mem_flags [0:DEPTH-1];

  always_ff @(posedge forever_cpuclk) begin
    for (int i = 0; i < 3; i++) begin
      if (cv[i]) begin
        mem_preg[slot[i]]  <= cp[i];
        mem_data[slot[i]]  <= cd[i];
        mem_flags[slot[i]] <= cf[i];
      end
    end
  end

  // Head fields are forced to zero when empty so stale entries never leak out.
  assign wb_vld    = (cnt_reg != '0);
  assign wb_preg   = wb_vld ? mem_preg[rd_ptr_reg]  : '0;
  assign wb_data   = wb_vld ? mem_data[rd_ptr_reg]  : '0;
  assign wb_fflags = wb_vld ? mem_flags[rd_ptr_reg] : '0;
  assign pop       = wb_vld & wb_ready;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(enq);
      rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
      cnt_reg    <= cnt_reg + enq - CNT_W'(pop);
      if (fflags_clr)
        acc_reg <= pop ? wb_fflags : 5'd0;
      else if (pop)
        acc_reg <= acc_reg | wb_fflags;
    end
  end

  assign fflags_acc      = acc_reg;
  assign wb_cnt          = cnt_reg;
  assign vfmau_stall_req = (DEPTH_C - cnt_reg) < CNT_W'(3);

  assert property (@(posedge forever_cpuclk) disable iff (cpurst)
    ({1'b0, cnt_reg} + {1'b0, enq}) <= ({1'b0, DEPTH_C} + {{CNT_W{1'b0}}, pop}));

endmodule

// File: tb/tb_aq_vpu_vfmau_wb_collect.sv
// Directed scenarios plus randomized traffic, checked against an op-level
// model (list of in-flight ops and an expected writeback queue).
module tb_aq_vpu_vfmau_wb_collect;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel, s1, s2, s3, s4, s5, flush, rdy3, rdy4, wb_ready, clr;
  logic [9:0]  eu_sel;
  logic [5:0]  dst;
  logic [63:0] r3, r4, r5;
  logic [4:0]  f3, f4, f5;
  logic        wb_vld, stall_req;
  logic [5:0]  wb_preg;
  logic [63:0] wb_data;
  logic [4:0]  wb_fflags, fflags_acc;
  logic [2:0]  wb_cnt;

  aq_vpu_vfmau_wb_collect #(.FMAU_SEL_BIT(2), .DEPTH(DEPTH), .PREG_W(6), .DATA_W(64)) dut (
    .forever_cpuclk(clk), .cpurst(rst),
    .vpu_group_0_xx_ex1_sel(sel), .vpu_group_0_xx_ex1_eu_sel(eu_sel),
    .vpu_group_0_xx_ex1_dst_preg(dst),
    .vpu_group_0_xx_ex1_stall(s1), .vpu_group_0_xx_ex2_stall(s2), .vpu_group_0_xx_ex3_stall(s3),
    .vpu_group_0_xx_ex4_stall(s4), .vpu_group_0_xx_ex5_stall(s5),
    .vpu_group_0_xx_flush(flush),
    .vfmau_vpu_ex2_result_ready_in_ex3(rdy3), .vfmau_vpu_ex3_result_ready_in_ex4(rdy4),
    .vfmau_vpu_ex3_fpr_result(r3), .vfmau_vpu_ex4_fpr_result(r4), .vfmau_vpu_ex5_fpr_result(r5),
    .vfmau_vpu_ex3_fflags(f3), .vfmau_vpu_ex4_fflags(f4), .vfmau_vpu_ex5_fflags(f5),
    .wb_ready(wb_ready), .fflags_clr(clr),
    .wb_vld(wb_vld), .wb_preg(wb_preg), .wb_data(wb_data), .wb_fflags(wb_fflags),
    .fflags_acc(fflags_acc), .vfmau_stall_req(stall_req), .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] preg; int stg; bit done; } op_t;
  typedef struct { logic [5:0] preg; logic [63:0] data; logic [4:0] fl; } ent_t;
  op_t        ops[$];
  ent_t       q[$];
  logic [4:0] acc_m = 5'd0;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_next();
    op_t  nxt[$];
    op_t  o;
    ent_t e;
    bit   pop;
    bit [6:1] st;
    logic [63:0] r [2:5];
    logic [4:0]  f [2:5];
    st = {1'b0, s5, s4, s3, s2, s1};
    r[2] = '0; r[3] = r3; r[4] = r4; r[5] = r5;
    f[2] = '0; f[3] = f3; f[4] = f4; f[5] = f5;
    pop = wb_ready && (q.size() > 0);
    if (clr) acc_m = pop ? q[0].fl : 5'd0;
    else if (pop) acc_m = acc_m | q[0].fl;
    if (pop) begin
      $display("pop  preg=%0d data=%h flags=%b", q[0].preg, q[0].data, q[0].fl);
      void'(q.pop_front());
    end
    foreach (ops[i]) begin
      o = ops[i];
      if (st[o.stg]) begin
        nxt.push_back(o);
      end else if (o.done) begin
        e.preg = o.preg; e.data = r[o.stg]; e.fl = f[o.stg];
        q.push_back(e);
      end else if (!st[o.stg+1]) begin
        o.stg  = o.stg + 1;
        o.done = (o.stg == 3) ? rdy3 : (o.stg == 4) ? rdy4 : 1'b1;
        nxt.push_back(o);
      end
    end
    if (sel && eu_sel[2] && !st[1] && !st[2]) begin
      o.preg = dst; o.stg = 2; o.done = 1'b0;
      nxt.push_back(o);
    end
    if (flush) nxt.delete();
    ops = nxt;
  endtask

  task automatic compare_all();
    check("wb_vld", 64'(wb_vld), 64'(q.size() != 0));
    check("wb_cnt", 64'(wb_cnt), 64'(q.size()));
    check("stall_req", 64'(stall_req), 64'((DEPTH - q.size()) < 3));
    check("fflags_acc", 64'(fflags_acc), 64'(acc_m));
    if (q.size() != 0) begin
      check("head_preg", 64'(wb_preg), 64'(q[0].preg));
      check("head_data", wb_data, q[0].data);
      check("head_flags", 64'(wb_fflags), 64'(q[0].fl));
    end
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    sel = 1'b0; eu_sel = 10'h000; dst = '0;
    {s1, s2, s3, s4, s5} = '0;
    flush = 1'b0; rdy3 = 1'b0; rdy4 = 1'b0; wb_ready = 1'b0; clr = 1'b0;
    r3 = {$urandom, $urandom}; r4 = {$urandom, $urandom}; r5 = {$urandom, $urandom};
    f3 = 5'($urandom_range(0, 31)); f4 = 5'($urandom_range(0, 31)); f5 = 5'($urandom_range(0, 31));
  endtask

  // Issue one op that completes in ex3 with the given result.
  task automatic run_op(input logic [5:0] p, input logic [63:0] d, input logic [4:0] fl);
    idle(); sel = 1'b1; eu_sel = 10'h004; dst = p; tick();
    idle(); rdy3 = 1'b1; tick();
    idle(); r3 = d; f3 = fl; tick();
  endtask

  task automatic rand_drive();
    s1 = $urandom_range(0, 99) < 10; s2 = $urandom_range(0, 99) < 10;
    s3 = $urandom_range(0, 99) < 10; s4 = $urandom_range(0, 99) < 10;
    s5 = $urandom_range(0, 99) < 10;
    flush = $urandom_range(0, 99) < 3;
    wb_ready = $urandom_range(0, 99) < 60;
    clr = $urandom_range(0, 99) < 8;
    rdy3 = 1'($urandom_range(0, 1)); rdy4 = 1'($urandom_range(0, 1));
    r3 = {$urandom, $urandom}; r4 = {$urandom, $urandom}; r5 = {$urandom, $urandom};
    f3 = 5'($urandom_range(0, 31)); f4 = 5'($urandom_range(0, 31)); f5 = 5'($urandom_range(0, 31));
    eu_sel = 10'($urandom_range(0, 1023)); dst = 6'($urandom_range(0, 63));
    sel = ($urandom_range(0, 99) < 70) && (q.size() + ops.size() < DEPTH) && (q.size() < DEPTH - 2);
  endtask

  initial begin
    idle();
    repeat (3) @(negedge clk);
    check("rst_vld", 64'(wb_vld), 64'(0));
    check("rst_cnt", 64'(wb_cnt), 64'(0));
    check("rst_preg", 64'(wb_preg), 64'(0));
    check("rst_data", wb_data, 64'(0));
    check("rst_flags", 64'(wb_fflags), 64'(0));
    check("rst_acc", 64'(fflags_acc), 64'(0));
    check("rst_stall", 64'(stall_req), 64'(0));
    rst = 1'b0;

    // Single ex3-path op.
    run_op(6'd5, 64'hDEAD_BEEF_0000_0005, 5'd0);
    check("p5_vld", 64'(wb_vld), 64'(1));
    check("p5_preg", 64'(wb_preg), 64'(5));
    check("p5_data", wb_data, 64'hDEAD_BEEF_0000_0005);
    idle(); wb_ready = 1'b1; tick();
    check("p5_drained", 64'(wb_vld), 64'(0));

    // A on the ex5 path, B one cycle later finishing in ex4: same-cycle completion.
    idle(); sel = 1'b1; eu_sel = 10'h004; dst = 6'd10; tick();
    idle(); sel = 1'b1; eu_sel = 10'h004; dst = 6'd11; tick();
    idle(); tick();
    idle(); rdy4 = 1'b1; tick();
    idle(); r5 = 64'hAAAA_0000_0000_000A; r4 = 64'hBBBB_0000_0000_000B; tick();
    check("ab_cnt", 64'(wb_cnt), 64'(2));
    check("ab_first", 64'(wb_preg), 64'(10));
    idle(); wb_ready = 1'b1; tick();
    check("ab_second", 64'(wb_preg), 64'(11));
    check("ab_second_data", wb_data, 64'hBBBB_0000_0000_000B);
    idle(); wb_ready = 1'b1; tick();

    // Back-pressure: two entries held, stall requested, head stable.
    run_op(6'd20, 64'h20, 5'd0);
    run_op(6'd21, 64'h21, 5'd0);
    check("bp_cnt", 64'(wb_cnt), 64'(2));
    check("bp_stall", 64'(stall_req), 64'(1));
    idle(); tick();
    check("bp_hold_preg", 64'(wb_preg), 64'(20));
    idle(); wb_ready = 1'b1; tick();
    check("bp_pop2", 64'(wb_preg), 64'(21));
    idle(); wb_ready = 1'b1; tick();

    // Done op held in ex4 for three cycles.
    idle(); sel = 1'b1; eu_sel = 10'h004; dst = 6'd40; tick();
    idle(); tick();
    idle(); rdy4 = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      idle(); s4 = 1'b1; tick();
      check("ex4hold_cnt", 64'(wb_cnt), 64'(0));
    end
    idle(); tick();
    check("ex4rel_cnt", 64'(wb_cnt), 64'(1));
    idle(); wb_ready = 1'b1; tick();

    // Sticky flags and clear-with-pop priority.
    idle(); clr = 1'b1; tick();
    run_op(6'd1, 64'h1, 5'b00001);
    run_op(6'd2, 64'h2, 5'b10000);
    idle(); wb_ready = 1'b1; tick();
    idle(); wb_ready = 1'b1; tick();
    check("acc_or", 64'(fflags_acc), 64'(5'b10001));
    run_op(6'd3, 64'h3, 5'b00100);
    idle(); wb_ready = 1'b1; clr = 1'b1; tick();
    check("acc_clr_pop", 64'(fflags_acc), 64'(5'b00100));

    // Flush with not-done ops in ex4 and ex2.
    idle(); sel = 1'b1; eu_sel = 10'h004; dst = 6'd30; tick();
    idle(); tick();
    idle(); sel = 1'b1; eu_sel = 10'h004; dst = 6'd31; tick();
    idle(); flush = 1'b1; tick();
    repeat (4) begin idle(); tick(); end
    check("flush_cnt", 64'(wb_cnt), 64'(0));

    // Async reset with three queued entries.
    run_op(6'd50, 64'h50, 5'd1);
    run_op(6'd51, 64'h51, 5'd2);
    run_op(6'd52, 64'h52, 5'd3);
    check("pre_rst_cnt", 64'(wb_cnt), 64'(3));
    rst = 1'b1;
    #1;
    check("arst_vld", 64'(wb_vld), 64'(0));
    check("arst_cnt", 64'(wb_cnt), 64'(0));
    q.delete(); ops.delete(); acc_m = 5'd0;
    idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 1500; n++) begin
      rand_drive();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
